// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/exec/mem control sequencer with PC (optional CYCLE_COUNT_EN counters)
module instr_sequencer #(
    parameter int PC_WIDTH    = 10,
    parameter int OFF_WIDTH   = 6,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 dec_jump,
    input  logic                 dec_halt,
    input  logic                 dec_branch,
    input  logic                 dec_reg_write,
    input  logic                 dec_mem_read,
    input  logic                 dec_mem_write,
    input  logic [OFF_WIDTH-1:0] jump_off,
    input  logic                 alu_zero,
    input  logic                 mem_ack,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 ir_load,
    output logic                 reg_write_en,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 busy,
    output logic                 done,
`ifdef CYCLE_COUNT_EN
    output logic                 err,
    output logic [31:0]          cycle_count,
    output logic [31:0]          instr_count
`else
    output logic                 err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALTED
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PC_WIDTH-1:0] pc_step;
    logic [PC_WIDTH-1:0] off_ext;
    logic [7:0]          tmo_cnt;
    logic [7:0]          tmo_inc;
    logic                done_r;
    logic                err_r;
    logic                accept_start;
    logic                advance;
    logic                enter_mem;
    logic                mem_wait;
    logic                set_done;
    logic                set_err;

    assign off_ext = {{(PC_WIDTH-OFF_WIDTH){jump_off[OFF_WIDTH-1]}}, jump_off};
    assign tmo_inc = tmo_cnt + 8'd1;
    assign busy    = (state == S_FETCH) || (state == S_EXEC) || (state == S_MEM);
    assign done    = done_r;
    assign err     = err_r;

    // Successor PC: jump beats taken branch beats sequential; wraps modulo 2^PC_WIDTH
    always_comb begin
        pc_step = pc + PC_WIDTH'(1);
        if (dec_jump)
            pc_step = pc + off_ext;
        else if (dec_branch && alu_zero)
            pc_step = pc + PC_WIDTH'(2);
    end

    // Next-state decode and per-state strobes; strobes only exist in the cycle that commits
    always_comb begin
        state_nxt    = state;
        ir_load      = 1'b0;
        reg_write_en = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        accept_start = 1'b0;
        advance      = 1'b0;
        enter_mem    = 1'b0;
        mem_wait     = 1'b0;
        set_done     = 1'b0;
        set_err      = 1'b0;
        case (state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_nxt    = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_load   = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (dec_halt) begin
                    set_done  = 1'b1;
                    state_nxt = S_HALTED;
                end else if (dec_mem_read || dec_mem_write) begin
                    enter_mem = 1'b1;
                    state_nxt = S_MEM;
                end else begin
                    reg_write_en = dec_reg_write;
                    advance      = 1'b1;
                    state_nxt    = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = dec_mem_write;
                if (mem_ack) begin
                    // Stores never write the register file, whatever the decoder says
                    reg_write_en = dec_mem_read;
                    advance      = 1'b1;
                    state_nxt    = S_FETCH;
                end else if (tmo_inc == 8'(MEM_TIMEOUT)) begin
                    set_err   = 1'b1;
                    state_nxt = S_HALTED;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // PC, memory-wait counter and halt status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= '0;
            tmo_cnt <= 8'd0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            if (accept_start) begin
                pc     <= '0;
                done_r <= 1'b0;
                err_r  <= 1'b0;
            end
            if (advance)
                pc <= pc_step;
            if (enter_mem)
                tmo_cnt <= 8'd0;
            else if (mem_wait)
                tmo_cnt <= tmo_inc;
            if (set_done) begin
                done_r <= 1'b1;
                err_r  <= 1'b0;
            end
            if (set_err) begin
                err_r  <= 1'b1;
                done_r <= 1'b0;
            end
        end
    end

`ifdef CYCLE_COUNT_EN
    // Saturating busy-cycle and fetch counters, cleared when a run starts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= 32'd0;
            instr_count <= 32'd0;
        end else if (accept_start) begin
            cycle_count <= 32'd0;
            instr_count <= 32'd0;
        end else begin
            if (busy && (cycle_count != 32'hFFFF_FFFF))
                cycle_count <= cycle_count + 32'd1;
            if ((state == S_FETCH) && (instr_count != 32'hFFFF_FFFF))
                instr_count <= instr_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - randomized self-checking bench for instr_sequencer
module tb_instr_sequencer;

    localparam int PC_WIDTH    = 10;
    localparam int OFF_WIDTH   = 6;
    localparam int MEM_TIMEOUT = 15;
    localparam int PC_MOD      = 1 << PC_WIDTH;

    localparam int K_ALU   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_HALT  = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic                 dec_jump = 1'b0;
    logic                 dec_halt = 1'b0;
    logic                 dec_branch = 1'b0;
    logic                 dec_reg_write = 1'b0;
    logic                 dec_mem_read = 1'b0;
    logic                 dec_mem_write = 1'b0;
    logic [OFF_WIDTH-1:0] jump_off = '0;
    logic                 alu_zero = 1'b0;
    logic                 mem_ack = 1'b0;
    logic [PC_WIDTH-1:0]  pc;
    logic                 ir_load;
    logic                 reg_write_en;
    logic                 mem_req;
    logic                 mem_we;
    logic                 busy;
    logic                 done;
    logic                 err;
`ifdef CYCLE_COUNT_EN
    logic [31:0]          cycle_count;
    logic [31:0]          instr_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int mpc = 0;
    bit halted = 1'b0;

    instr_sequencer #(
        .PC_WIDTH   (PC_WIDTH),
        .OFF_WIDTH  (OFF_WIDTH),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .dec_jump     (dec_jump),
        .dec_halt     (dec_halt),
        .dec_branch   (dec_branch),
        .dec_reg_write(dec_reg_write),
        .dec_mem_read (dec_mem_read),
        .dec_mem_write(dec_mem_write),
        .jump_off     (jump_off),
        .alu_zero     (alu_zero),
        .mem_ack      (mem_ack),
        .pc           (pc),
        .ir_load      (ir_load),
        .reg_write_en (reg_write_en),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .busy         (busy),
        .done         (done),
`ifdef CYCLE_COUNT_EN
        .err          (err),
        .cycle_count  (cycle_count),
        .instr_count  (instr_count)
`else
        .err          (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (pc model %0d, t=%0t)", tag, obs, exp, mpc, $time);
        end
    endtask

    // Reference PC rule: signed offset jump, skip-one on taken branch, else +1, all modulo 2^PC_WIDTH
    function automatic int model_next(input int p, input logic j, input logic b, input logic z,
                                      input logic [OFF_WIDTH-1:0] off);
        int s;
        s = int'(off);
        if (s >= (1 << (OFF_WIDTH - 1)))
            s = s - (1 << OFF_WIDTH);
        if (j)
            return (p + s + PC_MOD) % PC_MOD;
        if (b && z)
            return (p + 2) % PC_MOD;
        return (p + 1) % PC_MOD;
    endfunction

    task automatic restart();
        @(negedge clk);
        start = 1'b1;
        dec_halt = 1'b0;
        dec_mem_read = 1'b0;
        dec_mem_write = 1'b0;
        mem_ack = 1'b0;
        #1;
        expect_eq("start_busy", 32'(busy), 0);
        expect_eq("start_req", 32'(mem_req), 0);
        mpc = 0;
        halted = 1'b0;
    endtask

    // One full instruction: FETCH, EXEC, then MEM cycles if it is a load/store.
    // ack_at is the MEM cycle (1-based) carrying mem_ack; beyond MEM_TIMEOUT means no ack at all.
    task automatic do_instr(input int kind, input logic j, input logic b, input logic z,
                            input logic rw, input logic [OFF_WIDTH-1:0] off, input int ack_at);
        logic ack;
        int req_cycles;
        @(negedge clk);
        dec_jump      = j;
        dec_branch    = b;
        alu_zero      = z;
        dec_reg_write = rw;
        dec_halt      = (kind == K_HALT);
        dec_mem_read  = (kind == K_LOAD);
        dec_mem_write = (kind == K_STORE);
        jump_off      = off;
        mem_ack       = 1'b0;
        start         = 1'($urandom_range(0, 1));
        #1;
        expect_eq("fetch_ir_load", 32'(ir_load), 1);
        expect_eq("fetch_pc", 32'(pc), 32'(mpc));
        expect_eq("fetch_busy", 32'(busy), 1);
        expect_eq("fetch_rwe", 32'(reg_write_en), 0);
        expect_eq("fetch_req", 32'(mem_req), 0);
        expect_eq("fetch_done", 32'(done), 0);
        expect_eq("fetch_err", 32'(err), 0);

        @(negedge clk);
        start = 1'($urandom_range(0, 1));
        #1;
        expect_eq("exec_ir_load", 32'(ir_load), 0);
        expect_eq("exec_pc", 32'(pc), 32'(mpc));
        expect_eq("exec_busy", 32'(busy), 1);
        expect_eq("exec_req", 32'(mem_req), 0);
        if (kind == K_HALT) begin
            expect_eq("exec_halt_rwe", 32'(reg_write_en), 0);
            @(negedge clk);
            start = 1'b0;
            #1;
            expect_eq("halt_done", 32'(done), 1);
            expect_eq("halt_err", 32'(err), 0);
            expect_eq("halt_busy", 32'(busy), 0);
            expect_eq("halt_pc", 32'(pc), 32'(mpc));
            expect_eq("halt_ir_load", 32'(ir_load), 0);
            halted = 1'b1;
            return;
        end
        if (kind == K_ALU) begin
            expect_eq("exec_rwe", 32'(reg_write_en), 32'(rw));
            mpc = model_next(mpc, j, b, z, off);
            return;
        end
        expect_eq("exec_mem_rwe", 32'(reg_write_en), 0);

        req_cycles = 0;
        for (int i = 1; i <= MEM_TIMEOUT; i++) begin
            @(negedge clk);
            ack = (i == ack_at);
            mem_ack = ack;
            start = 1'($urandom_range(0, 1));
            #1;
            if (mem_req) req_cycles++;
            expect_eq("mem_req", 32'(mem_req), 1);
            expect_eq("mem_we", 32'(mem_we), 32'(kind == K_STORE));
            expect_eq("mem_rwe", 32'(reg_write_en), 32'(ack && (kind == K_LOAD)));
            expect_eq("mem_pc", 32'(pc), 32'(mpc));
            expect_eq("mem_busy", 32'(busy), 1);
            if (ack) begin
                expect_eq("mem_req_cycles", 32'(req_cycles), 32'(ack_at));
                mpc = model_next(mpc, j, b, z, off);
                return;
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        start = 1'b0;
        #1;
        expect_eq("tmo_req_cycles", 32'(req_cycles), 32'(MEM_TIMEOUT));
        expect_eq("tmo_err", 32'(err), 1);
        expect_eq("tmo_done", 32'(done), 0);
        expect_eq("tmo_req", 32'(mem_req), 0);
        expect_eq("tmo_busy", 32'(busy), 0);
        expect_eq("tmo_pc", 32'(pc), 32'(mpc));
        halted = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        #1;
        expect_eq("rst_pc", 32'(pc), 0);
        expect_eq("rst_busy", 32'(busy), 0);
        expect_eq("rst_done", 32'(done), 0);
        expect_eq("rst_err", 32'(err), 0);
        expect_eq("rst_req", 32'(mem_req), 0);
        expect_eq("rst_ir_load", 32'(ir_load), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        expect_eq("idle_busy", 32'(busy), 0);

        // Directed: ADD, walk to pc=5, jump -2, walk to 8, BEQ taken / not taken
        restart();
        for (int i = 0; i < 5; i++) do_instr(K_ALU, 0, 0, 0, 1, '0, 0);
        do_instr(K_ALU, 1, 0, 0, 1, 6'b111110, 0);
        expect_eq("jump_back_model", 32'(mpc), 3);
        for (int i = 0; i < 5; i++) do_instr(K_ALU, 0, 0, 0, 0, '0, 0);
        do_instr(K_ALU, 0, 1, 1, 0, '0, 0);
        do_instr(K_ALU, 0, 1, 0, 0, '0, 0);
        // Load acked in 3rd MEM cycle, store with reg_write set, ack exactly at the timeout edge, timeout
        do_instr(K_LOAD, 0, 0, 0, 1, '0, 3);
        do_instr(K_STORE, 0, 0, 0, 1, '0, 2);
        do_instr(K_LOAD, 0, 0, 0, 1, '0, MEM_TIMEOUT);
        do_instr(K_LOAD, 0, 0, 0, 1, '0, 99);
        // Restart after error, jump wrap below zero, then halt with jump also set
        restart();
        do_instr(K_ALU, 1, 0, 0, 0, 6'b111111, 0);
        expect_eq("wrap_model", 32'(mpc), 1023);
        do_instr(K_HALT, 1, 0, 0, 1, '0, 0);
        restart();

        for (int n = 0; n < 400; n++) begin
            if (halted) restart();
            kind = int'($urandom_range(0, 9));
            kind = (kind < 5) ? K_ALU : (kind < 7) ? K_LOAD : (kind < 9) ? K_STORE : K_HALT;
            do_instr(kind, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     OFF_WIDTH'($urandom), int'($urandom_range(1, MEM_TIMEOUT + 3)));
        end

        // Asynchronous reset while a load is waiting in MEM
        if (halted) restart();
        @(negedge clk);
        dec_halt = 1'b0;
        dec_mem_read = 1'b1;
        dec_mem_write = 1'b0;
        mem_ack = 1'b0;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        expect_eq("pre_rst_req", 32'(mem_req), 1);
        #2;
        reset = 1'b1;
        #1;
        expect_eq("async_rst_req", 32'(mem_req), 0);
        expect_eq("async_rst_busy", 32'(busy), 0);
        expect_eq("async_rst_pc", 32'(pc), 0);
        @(negedge clk);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
